// File: rtl/mips_pkg.sv
// Shared loader definitions: state encoding and instruction-memory geometry.
// Imported by the loader top, its byte packer and the loader interface.
package mips_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } loader_state_t;

   localparam int IMEM_ADDR_WIDTH = 10;
   localparam int WORD_BYTES      = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port of the loader.
// master = loader side, slave = host link / memory side.
interface imem_loader_if
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = 32
);

   logic [7:0]            in_byte;
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] imem_address;
   logic [DATA_WIDTH-1:0] imem_datain;
   logic                  imem_write;

   modport master (
      input  in_byte, in_valid,
      output in_ready, imem_address, imem_datain, imem_write
   );

   modport slave (
      output in_byte, in_valid,
      input  in_ready, imem_address, imem_datain, imem_write
   );

endinterface

// File: rtl/byte_word_packer.sv
// Packs MSB-first bytes into a word; word_vld fires combinationally with the last byte.
// No backpressure of its own: every byte_vld is consumed.
module byte_word_packer
   import mips_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      byte_vld,
   input  logic [7:0]                byte_dat,
   output logic [8*WORD_BYTES-1:0]   word_dat,
   output logic                      word_vld
);

   localparam int CW = $clog2(WORD_BYTES);
   localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

   logic [8*WORD_BYTES-9:0] shift;
   logic [CW-1:0]           count;

   assign word_vld = byte_vld && (count == LAST);
   assign word_dat = {shift, byte_dat};

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         shift <= '0;
         count <= '0;
      end else if (byte_vld) begin
         shift <= {shift[8*WORD_BYTES-17:0], byte_dat};
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian program image into instruction memory, holding the core meanwhile.
// Write strobe one cycle after the 4th byte of each word; in_ready is a registered state decode.
module imem_loader
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH     = IMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   imem_loader_if.master       bus,
   output logic                cpu_hold,
   output logic                done,
   output logic                error,
   output logic [ADDR_WIDTH:0] words_loaded
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
   localparam logic [31:0]   MAX_WORDS = 32'(2 ** ADDR_WIDTH);

   loader_state_t         state;
   logic [ADDR_WIDTH:0]   len;
   logic [ADDR_WIDTH:0]   wl_next;
   logic [TW-1:0]         to_cnt;
   logic                  xfer;
   logic                  restart;
   logic                  timed_out;
   logic                  word_vld;
   logic [DATA_WIDTH-1:0] word_dat;

   assign xfer      = bus.in_valid && bus.in_ready;
   assign restart   = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
   assign wl_next   = words_loaded + (ADDR_WIDTH + 1)'(1);
   assign timed_out = !xfer && (to_cnt == TO_LAST);

   byte_word_packer u_packer (
      .clk      (clk),
      .reset    (reset),
      .clear    (restart),
      .byte_vld (xfer),
      .byte_dat (bus.in_byte),
      .word_dat (word_dat),
      .word_vld (word_vld)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_IDLE;
         bus.in_ready     <= 1'b0;
         bus.imem_write   <= 1'b0;
         bus.imem_address <= '0;
         bus.imem_datain  <= '0;
         cpu_hold         <= 1'b1;
         done             <= 1'b0;
         error            <= 1'b0;
         words_loaded     <= '0;
         len              <= '0;
         to_cnt           <= '0;
      end else begin
         bus.imem_write <= 1'b0;

         // Idle-gap counter only runs while bytes are expected.
         if (state == ST_LEN || state == ST_DATA) begin
            if (xfer)
               to_cnt <= '0;
            else if (to_cnt != TO_MAX)
               to_cnt <= to_cnt + TW'(1);
         end

         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  state        <= ST_LEN;
                  bus.in_ready <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  cpu_hold     <= 1'b1;
                  words_loaded <= '0;
                  to_cnt       <= '0;
               end
            end

            ST_LEN: begin
               if (word_vld) begin
                  if (word_dat == '0) begin
                     state        <= ST_DONE;
                     bus.in_ready <= 1'b0;
                     done         <= 1'b1;
                     cpu_hold     <= 1'b0;
                  end else if (word_dat > MAX_WORDS) begin
                     state        <= ST_ERROR;
                     bus.in_ready <= 1'b0;
                     error        <= 1'b1;
                  end else begin
                     state <= ST_DATA;
                     len   <= word_dat[ADDR_WIDTH:0];
                  end
               end else if (timed_out) begin
                  state        <= ST_ERROR;
                  bus.in_ready <= 1'b0;
                  error        <= 1'b1;
               end
            end

            ST_DATA: begin
               // words_loaded reaches len in the strobe cycle of the last word.
               if (words_loaded == len) begin
                  state    <= ST_DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
               end else if (word_vld) begin
                  bus.imem_write   <= 1'b1;
                  bus.imem_address <= words_loaded[ADDR_WIDTH-1:0];
                  bus.imem_datain  <= word_dat;
                  words_loaded     <= wl_next;
                  if (wl_next == len)
                     bus.in_ready <= 1'b0;
               end else if (timed_out) begin
                  state        <= ST_ERROR;
                  bus.in_ready <= 1'b0;
                  error        <= 1'b1;
               end
            end

            default: begin
               state        <= ST_IDLE;
               bus.in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
